// File: rtl/mmio_bus_arbiter.sv
// Two-master round-robin front end for the single MMIO bus. One transaction is
// in flight at a time: IDLE grants, ISSUE strobes the bus, ACK returns to the master.
module mmio_bus_arbiter #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rd_data,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              mmio_cs,
    output logic              mmio_wr,
    output logic              mmio_rd,
    output logic [ADDR_W-1:0] mmio_addr,
    output logic [DATA_W-1:0] mmio_wr_data,
    input  logic [DATA_W-1:0] mmio_rd_data,
    output logic              busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_ACK} state_t;

    state_t            r_state, w_state_next;
    logic              r_last_grant, w_last_grant_next;
    logic              r_grant, w_grant_next;
    logic              r_cs, w_cs_next;
    logic              r_wr, w_wr_next;
    logic              r_rd, w_rd_next;
    logic [ADDR_W-1:0] r_addr, w_addr_next;
    logic [DATA_W-1:0] r_wr_data, w_wr_data_next;
    logic [1:0]        r_ack, w_ack_next;
    logic [DATA_W-1:0] r_rd_data [2];
    logic [DATA_W-1:0] w_rd_data_next [2];
    logic              w_winner;

    // On a tie the master that was not served last wins; otherwise the sole requester.
    assign w_winner = (m0_req && m1_req) ? ~r_last_grant : m1_req;

    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        w_grant_next      = r_grant;
        w_cs_next         = 1'b0;
        w_wr_next         = 1'b0;
        w_rd_next         = 1'b0;
        w_addr_next       = r_addr;
        w_wr_data_next    = r_wr_data;
        w_ack_next        = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    w_grant_next      = w_winner;
                    w_last_grant_next = w_winner;
                    w_cs_next         = 1'b1;
                    w_wr_next         = w_winner ? m1_wr : m0_wr;
                    w_rd_next         = w_winner ? ~m1_wr : ~m0_wr;
                    w_addr_next       = w_winner ? m1_addr : m0_addr;
                    w_wr_data_next    = w_winner ? m1_wr_data : m0_wr_data;
                    w_state_next      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_ack_next[r_grant] = 1'b1;
                w_state_next        = ST_ACK;
            end
            ST_ACK:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_cs         <= 1'b0;
            r_wr         <= 1'b0;
            r_rd         <= 1'b0;
            r_addr       <= '0;
            r_wr_data    <= '0;
            r_ack        <= 2'b00;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
            r_grant      <= w_grant_next;
            r_cs         <= w_cs_next;
            r_wr         <= w_wr_next;
            r_rd         <= w_rd_next;
            r_addr       <= w_addr_next;
            r_wr_data    <= w_wr_data_next;
            r_ack        <= w_ack_next;
        end
    end

    // Read data is captured at the end of the strobe cycle into the granted master's register only.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                w_rd_data_next[gi] = r_rd_data[gi];
                if (r_state == ST_ISSUE && r_rd && r_grant == 1'(gi))
                    w_rd_data_next[gi] = mmio_rd_data;
            end

            always_ff @(posedge clk) begin
                if (reset) r_rd_data[gi] <= '0;
                else       r_rd_data[gi] <= w_rd_data_next[gi];
            end
        end
    endgenerate

    assign mmio_cs      = r_cs;
    assign mmio_wr      = r_wr;
    assign mmio_rd      = r_rd;
    assign mmio_addr    = r_addr;
    assign mmio_wr_data = r_wr_data;
    assign m0_ack       = r_ack[0];
    assign m1_ack       = r_ack[1];
    assign m0_rd_data   = r_rd_data[0];
    assign m1_rd_data   = r_rd_data[1];
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Bench for mmio_bus_arbiter: directed vector table, hand-written corner sequences,
// and a randomized two-master run against a transaction-level model.
module tb_mmio_bus_arbiter;
    localparam int AW = 21;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req [2];
    logic          wr [2];
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wdata [2];
    logic          m0_ack, m1_ack;
    logic [DW-1:0] m0_rdd, m1_rdd;
    logic          mmio_cs, mmio_wr, mmio_rd, busy;
    logic [AW-1:0] mmio_addr;
    logic [DW-1:0] mmio_wr_data, mmio_rd_data;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Slave model: read data is a fixed function of the bus address.
    function automatic logic [DW-1:0] rd_src(input logic [AW-1:0] a);
        if (a == 21'h00C00) return 32'h0000_00A5;
        return ({11'h2C5, a} * 32'd2654435761) ^ 32'h1357_9BDF;
    endfunction

    assign mmio_rd_data = rd_src(mmio_addr);

    mmio_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_req(req[0]), .m0_wr(wr[0]), .m0_addr(addr[0]), .m0_wr_data(wdata[0]),
        .m0_ack(m0_ack), .m0_rd_data(m0_rdd),
        .m1_req(req[1]), .m1_wr(wr[1]), .m1_addr(addr[1]), .m1_wr_data(wdata[1]),
        .m1_ack(m1_ack), .m1_rd_data(m1_rdd),
        .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
        .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data),
        .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rdd(input int m);
        return (m == 0) ? m0_rdd : m1_rdd;
    endfunction

    task automatic set_txn(input int m, input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[m] = r; wr[m] = w; addr[m] = a; wdata[m] = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int m = 0; m < 2; m++) set_txn(m, 1'b0, 1'b0, '0, '0);
        tick(); tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic          r0, r1, w0, w1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        int            win;
        logic [DW-1:0] exp_rd;
    } vec_t;

    function automatic vec_t mk(input logic r0, input logic w0, input logic [AW-1:0] a0,
                                input logic [DW-1:0] d0, input logic r1, input logic w1,
                                input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                input int win, input logic [DW-1:0] exp_rd);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.win = win; v.exp_rd = exp_rd;
        return v;
    endfunction

    vec_t vecs [6];

    // Random-run model state
    int            ack_due, new_due, last_srv, last_strobe, who;
    int            waitc [2];
    logic [DW-1:0] ack_data, due_data;
    logic [DW-1:0] exp_rd [2];
    logic          exp_cs, acked;
    int            acks_who [$];
    int            acks_cyc [$];
    int            strobes [$];

    initial begin
        // Reset state
        do_reset();
        reset = 1'b1;
        tick();
        chk("reset_outputs", {mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data, m0_ack, m1_ack, busy}, 64'h0);
        chk("reset_rd_data", {m0_rdd, m1_rdd}, 64'h0);
        reset = 1'b0;
        tick();

        // Directed single transactions; tie winners follow the alternation history.
        vecs[0] = mk(1, 0, 21'h00C00, 32'h0,        0, 0, 21'h0,     32'h0,        0, 32'h0000_00A5);
        vecs[1] = mk(0, 0, 21'h0,     32'h0,        1, 1, 21'h00400, 32'h0000_00FF, 1, 32'h0);
        vecs[2] = mk(1, 0, 21'h00010, 32'h0,        1, 0, 21'h00020, 32'h0,        0, rd_src(21'h00010));
        vecs[3] = mk(1, 1, 21'h00030, 32'h1234_5678, 1, 0, 21'h00040, 32'h0,        1, rd_src(21'h00040));
        vecs[4] = mk(0, 0, 21'h0,     32'h0,        1, 1, 21'h00050, 32'hCAFE_F00D, 1, rd_src(21'h00040));
        vecs[5] = mk(1, 0, 21'h00060, 32'h0,        1, 1, 21'h00070, 32'hDEAD_BEEF, 0, rd_src(21'h00060));

        for (int i = 0; i < 6; i++) begin
            logic          ew;
            logic [AW-1:0] ea;
            logic [DW-1:0] ed;
            set_txn(0, vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0);
            set_txn(1, vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
            ew = (vecs[i].win == 1) ? vecs[i].w1 : vecs[i].w0;
            ea = (vecs[i].win == 1) ? vecs[i].a1 : vecs[i].a0;
            ed = (vecs[i].win == 1) ? vecs[i].d1 : vecs[i].d0;
            tick();
            chk($sformatf("vec%0d_strobe", i), {mmio_cs, mmio_wr, mmio_rd}, {1'b1, ew, ~ew});
            chk($sformatf("vec%0d_addr", i), mmio_addr, ea);
            if (ew) chk($sformatf("vec%0d_wdata", i), mmio_wr_data, ed);
            chk($sformatf("vec%0d_issue_ack", i), {busy, m1_ack, m0_ack}, 3'b100);
            req[0] = 1'b0; req[1] = 1'b0;
            tick();
            chk($sformatf("vec%0d_ack", i), {mmio_cs, mmio_wr, mmio_rd, m1_ack, m0_ack},
                (vecs[i].win == 1) ? 5'b00010 : 5'b00001);
            chk($sformatf("vec%0d_rd_data", i), rdd(vecs[i].win), vecs[i].exp_rd);
            tick();
            chk($sformatf("vec%0d_idle", i), {busy, m1_ack, m0_ack}, 3'b000);
        end

        // Both masters held from reset: strict alternation, acks every 3 cycles.
        do_reset();
        set_txn(0, 1'b1, 1'b0, 21'h00100, '0);
        set_txn(1, 1'b1, 1'b0, 21'h00200, '0);
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (m0_ack || m1_ack) begin
                acks_who.push_back(m1_ack ? 1 : 0);
                acks_cyc.push_back(c);
            end
        end
        chk("alt_ack_count", acks_who.size(), 4);
        for (int k = 0; k < acks_who.size() && k < 4; k++) begin
            chk($sformatf("alt_who%0d", k), acks_who[k], k % 2);
            chk($sformatf("alt_cyc%0d", k), acks_cyc[k], 2 + 3 * k);
        end
        req[0] = 1'b0; req[1] = 1'b0;
        tick(); tick(); tick();

        // Reset asserted during ISSUE of an M0 read aborts with no ack.
        set_txn(0, 1'b1, 1'b0, 21'h00300, '0);
        tick();
        chk("abort_issue", {mmio_cs, mmio_rd}, 2'b11);
        reset = 1'b1;
        tick();
        chk("abort_outputs", {mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data, m0_ack, m1_ack, busy}, 64'h0);
        chk("abort_rd_data", {m0_rdd, m1_rdd}, 64'h0);
        reset = 1'b0;
        req[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("abort_no_ack", {m0_ack, busy}, 2'b00);
        end

        // Address change during ISSUE is ignored; then back-to-back held reads.
        set_txn(0, 1'b1, 1'b0, 21'h00500, '0);
        tick();
        chk("latch_addr", mmio_addr, 21'h00500);
        addr[0] = 21'h00600;
        tick();
        chk("latch_ack", m0_ack, 1'b1);
        chk("latch_rd_data", m0_rdd, rd_src(21'h00500));
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (mmio_cs) begin
                strobes.push_back(c);
                chk("b2b_addr", mmio_addr, 21'h00600);
            end
        end
        chk("b2b_count", strobes.size(), 3);
        for (int k = 0; k < strobes.size() && k < 3; k++)
            chk($sformatf("b2b_cyc%0d", k), strobes[k], 2 + 3 * k);
        req[0] = 1'b0;
        tick(); tick(); tick();

        // Randomized traffic against the transaction-level model.
        do_reset();
        ack_due = -1; last_srv = 1; last_strobe = -10;
        waitc[0] = 0; waitc[1] = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        due_data = '0;
        for (int cyc = 0; cyc < 1620; cyc++) begin
            tick();
            // A sampled request starts a strobe unless the previous one is under 3 cycles old.
            exp_cs = (req[0] || req[1]) && (cyc - last_strobe >= 3);
            chk("rnd_cs", mmio_cs, exp_cs);
            if (!mmio_cs) chk("rnd_idle_strobes", {mmio_wr, mmio_rd}, 2'b00);
            new_due = -1;
            if (exp_cs) begin
                who = (req[0] && req[1]) ? 1 - last_srv : (req[1] ? 1 : 0);
                chk("rnd_dir", {mmio_wr, mmio_rd}, {wr[who], ~wr[who]});
                chk("rnd_addr", mmio_addr, addr[who]);
                if (wr[who]) chk("rnd_wdata", mmio_wr_data, wdata[who]);
                last_srv = who;
                last_strobe = cyc;
                new_due = who;
                ack_data = wr[who] ? exp_rd[who] : rd_src(addr[who]);
            end
            chk("rnd_ack", {m1_ack, m0_ack}, (ack_due == 1) ? 2'b10 : (ack_due == 0) ? 2'b01 : 2'b00);
            chk("rnd_busy", busy, exp_cs || (ack_due >= 0));
            if (ack_due >= 0) exp_rd[ack_due] = due_data;
            for (int m = 0; m < 2; m++) begin
                chk("rnd_rd_data", rdd(m), exp_rd[m]);
                if (req[m]) begin
                    waitc[m]++;
                    chk("rnd_wait_bound", waitc[m] <= 10, 1'b1);
                end
            end
            for (int m = 0; m < 2; m++) begin
                acked = (ack_due == m);
                if ((acked || !req[m]) && cyc < 1600 && $urandom_range(0, 2) == 0) begin
                    set_txn(m, 1'b1, 1'($urandom_range(0, 1)),
                            ($urandom_range(0, 7) == 0) ? 21'h00C00 : 21'($urandom()), $urandom());
                    waitc[m] = 0;
                end else if (acked) begin
                    req[m] = 1'b0;
                end
            end
            ack_due = new_due;
            due_data = ack_data;
        end
        chk("rnd_drained", {req[0], req[1]}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
